// File: rtl/bus_responder.sv
// 68000-style bus cycle responder: synchronizes strobes and chip selects, inserts
// per-target wait states, issues DTACK, and raises a bus error when a cycle times out.
module bus_responder #(
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned ROM_WAIT     = 2,
  parameter int unsigned BERR_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic as_n,
  input  logic ram_cs_n,
  input  logic rom_cs_n,
  input  logic duart_cs_n,
  input  logic duart_dtack_n,
  output logic dtack_n,
  output logic berr_n,
  output logic bus_fault
);

  localparam int unsigned SYNC_W = 5;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned TMO_W  = 8;
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(BERR_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] RAM_WAIT_L = WAIT_W'(RAM_WAIT);
  localparam logic [WAIT_W-1:0] ROM_WAIT_L = WAIT_W'(ROM_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_BERR} state_t;
  typedef enum logic [1:0] {TGT_RAM, TGT_ROM, TGT_DUART, TGT_NONE} tgt_t;

  logic [SYNC_W-1:0] meta_q;
  logic [SYNC_W-1:0] sync_q;
  logic              as_s;
  logic              ram_cs_s;
  logic              rom_cs_s;
  logic              duart_cs_s;
  logic              duart_dtack_s;

  state_t            state_q;
  tgt_t              tgt_q;
  logic [WAIT_W-1:0] wait_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              armed_q;
  logic [1:0]        prime_q;
  logic              dtack_n_q;
  logic              berr_n_q;
  logic              fault_q;
  logic              ack_c;

  // Two-flop synchronizers for every asynchronous input; idle level is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= {as_n, ram_cs_n, rom_cs_n, duart_cs_n, duart_dtack_n};
      sync_q <= meta_q;
    end
  end

  assign as_s          = sync_q[4];
  assign ram_cs_s      = sync_q[3];
  assign rom_cs_s      = sync_q[2];
  assign duart_cs_s    = sync_q[1];
  assign duart_dtack_s = sync_q[0];

  // Acknowledge condition for the latched target while in WAIT.
  always_comb begin
    ack_c = 1'b0;
    case (tgt_q)
      TGT_RAM, TGT_ROM: ack_c = (wait_q == '0);
      TGT_DUART:        ack_c = !duart_dtack_s;
      default:          ack_c = 1'b0;
    endcase
  end

  // prime_q keeps the reset value of the synchronizer from counting as a real
  // strobe-high sample, so a strobe already low at reset release is never armed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tgt_q     <= TGT_NONE;
      wait_q    <= '0;
      tmo_q     <= '0;
      armed_q   <= 1'b0;
      prime_q   <= '0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      prime_q <= {prime_q[0], 1'b1};
      case (state_q)
        ST_IDLE: begin
          dtack_n_q <= 1'b1;
          berr_n_q  <= 1'b1;
          if (as_s) begin
            if (prime_q[1]) armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= ST_WAIT;
            armed_q <= 1'b0;
            tmo_q   <= '0;
            if (!ram_cs_s) begin
              tgt_q  <= TGT_RAM;
              wait_q <= RAM_WAIT_L;
            end else if (!rom_cs_s) begin
              tgt_q  <= TGT_ROM;
              wait_q <= ROM_WAIT_L;
            end else if (!duart_cs_s) begin
              tgt_q  <= TGT_DUART;
              wait_q <= '0;
            end else begin
              tgt_q  <= TGT_NONE;
              wait_q <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (as_s) begin
            state_q <= ST_IDLE;
          end else if (ack_c) begin
            state_q   <= ST_ACK;
            dtack_n_q <= 1'b0;
          end else if (tmo_q == TMO_LAST) begin
            state_q  <= ST_BERR;
            berr_n_q <= 1'b0;
            fault_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
            if (wait_q != '0) wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_ACK, ST_BERR: begin
          if (as_s) begin
            state_q   <= ST_IDLE;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dtack_n   = dtack_n_q;
  assign berr_n    = berr_n_q;
  assign bus_fault = fault_q;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: vector table plus a scoreboard of expected DTACK/BERR
// edges, and hand-written abort and reset sequences.
module tb_bus_responder;

  localparam int unsigned RAM_WAIT     = 0;
  localparam int unsigned ROM_WAIT     = 2;
  localparam int unsigned BERR_TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset, as_n, ram_cs_n, rom_cs_n, duart_cs_n, duart_dtack_n;
  logic dtack_n, berr_n, bus_fault;

  always #5 clk = ~clk;

  bus_responder #(
    .RAM_WAIT(RAM_WAIT), .ROM_WAIT(ROM_WAIT), .BERR_TIMEOUT(BERR_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .as_n(as_n), .ram_cs_n(ram_cs_n),
    .rom_cs_n(rom_cs_n), .duart_cs_n(duart_cs_n), .duart_dtack_n(duart_dtack_n),
    .dtack_n(dtack_n), .berr_n(berr_n), .bus_fault(bus_fault)
  );

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int t0 = 0;
  int overlap = 0;
  bit fault_exp = 1'b0;

  typedef struct {
    bit    is_berr;
    int    edge_n;
    string name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string name;
    bit    ram;
    bit    rom;
    bit    duart;
    int    dly;
    bit    exp_berr;
    int    exp_edge;
  } vec_t;
  vec_t vecs[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: each falling edge of dtack_n/berr_n pops one expected event.
  logic prev_dtack = 1'b1;
  logic prev_berr  = 1'b1;
  always @(posedge clk) begin : mon
    bit   got_berr;
    int   got_edge;
    exp_t e;
    #1;
    if (!dtack_n && !berr_n) overlap++;
    if ((prev_dtack && !dtack_n) || (prev_berr && !berr_n)) begin
      got_berr = !berr_n;
      got_edge = cyc_cnt - t0 - 1;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_response berr=%0b edge=%0d required no response",
                 got_berr, got_edge);
      end else begin
        e = sb_q.pop_front();
        if (e.is_berr != got_berr || e.edge_n != got_edge) begin
          failures++;
          $display("FAIL %s actual berr=%0b edge=%0d required berr=%0b edge=%0d",
                   e.name, got_berr, got_edge, e.is_berr, e.edge_n);
        end
      end
    end
    prev_dtack = dtack_n;
    prev_berr  = berr_n;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle(input int n);
    as_n = 1'b1; ram_cs_n = 1'b1; rom_cs_n = 1'b1; duart_cs_n = 1'b1; duart_dtack_n = 1'b1;
    repeat (n) cyc();
  endtask

  // Reference timing: strobe low before edge 0 reaches WAIT after edge 2.
  function automatic void model(input bit ram, input bit rom, input bit duart, input int dly,
                                output bit b, output int e);
    int tmo_edge = 2 + int'(BERR_TIMEOUT);
    int d_edge   = (dly + 2 > 3) ? dly + 2 : 3;
    b = 1'b0;
    if (ram)                                  e = 3 + int'(RAM_WAIT);
    else if (rom)                             e = 3 + int'(ROM_WAIT);
    else if (duart && dly >= 0 && d_edge <= tmo_edge) e = d_edge;
    else begin
      b = 1'b1;
      e = tmo_edge;
    end
  endfunction

  task automatic add_vec(input string name, input bit ram, input bit rom, input bit duart,
                         input int dly);
    vec_t v;
    v.name = name; v.ram = ram; v.rom = rom; v.duart = duart; v.dly = dly;
    model(ram, rom, duart, dly, v.exp_berr, v.exp_edge);
    vecs.push_back(v);
  endtask

  task automatic start_cycle(input bit ram, input bit rom, input bit duart, input int dly,
                             input bit eb, input int ee, input string name);
    exp_t e;
    as_n = 1'b0; ram_cs_n = !ram; rom_cs_n = !rom; duart_cs_n = !duart;
    duart_dtack_n = (dly == 0) ? 1'b0 : 1'b1;
    t0 = cyc_cnt;
    e.is_berr = eb; e.edge_n = ee; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic wait_response(input int dly, input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < 300) begin
      cyc();
      k++;
      if (dly > 0 && (cyc_cnt - t0 - 1) == dly - 1) duart_dtack_n = 1'b0;
    end
    if (sb_q.size() != 0) begin
      chk({name, "_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    start_cycle(v.ram, v.rom, v.duart, v.dly, v.exp_berr, v.exp_edge, v.name);
    wait_response(v.dly, v.name);
    if (v.exp_berr) fault_exp = 1'b1;
    chk({v.name, "_out"}, {30'd0, dtack_n, berr_n}, v.exp_berr ? 32'd2 : 32'd1);
    chk({v.name, "_fault"}, 32'(bus_fault), 32'(fault_exp));
    as_n = 1'b1;
    cyc(); cyc();
    chk({v.name, "_hold"}, {30'd0, dtack_n, berr_n}, v.exp_berr ? 32'd2 : 32'd1);
    cyc();
    chk({v.name, "_release"}, {30'd0, dtack_n, berr_n}, 32'd3);
    chk({v.name, "_fault_after"}, 32'(bus_fault), 32'(fault_exp));
    bus_idle(3);
  endtask

  initial begin
    int lows;
    vec_t rv;
    reset = 1'b0;
    bus_idle(3);
    chk("reset_outputs", {29'd0, dtack_n, berr_n, bus_fault}, 32'd6);
    reset = 1'b1;
    bus_idle(4);

    add_vec("ram",            1, 0, 0, 0);
    add_vec("rom",            0, 1, 0, 0);
    add_vec("duart_d10",      0, 0, 1, 10);
    add_vec("duart_d0",       0, 0, 1, 0);
    add_vec("duart_d3",       0, 0, 1, 3);
    add_vec("ram_over_rom",   1, 1, 0, 0);
    add_vec("rom_over_duart", 0, 1, 1, 0);
    add_vec("duart_d63",      0, 0, 1, 63);
    add_vec("duart_d64_tie",  0, 0, 1, 64);
    add_vec("duart_d65",      0, 0, 1, 65);
    add_vec("duart_never",    0, 0, 1, -1);
    add_vec("unmapped",       0, 0, 0, 0);
    foreach (vecs[i]) run_vec(vecs[i]);

    // Strobe released during ROM wait states: no acknowledge may appear.
    as_n = 1'b0; rom_cs_n = 1'b0;
    cyc(); cyc();
    as_n = 1'b1;
    lows = 0;
    repeat (12) begin
      cyc();
      if (!dtack_n) lows++;
    end
    chk("abort_no_dtack", 32'(lows), 32'd0);
    bus_idle(3);

    // Reset while acknowledging, with the strobe still low after release.
    start_cycle(1, 0, 0, 0, 1'b0, 3 + int'(RAM_WAIT), "ram_pre_reset");
    wait_response(0, "ram_pre_reset");
    chk("pre_reset_dtack", 32'(dtack_n), 32'd0);
    reset = 1'b0;
    cyc();
    fault_exp = 1'b0;
    chk("reset_in_ack", {29'd0, dtack_n, berr_n, bus_fault}, 32'd6);
    reset = 1'b1;
    lows = 0;
    repeat (12) begin
      cyc();
      if (!dtack_n || !berr_n) lows++;
    end
    chk("stale_strobe_ignored", 32'(lows), 32'd0);
    bus_idle(4);
    rv = vecs[0];
    rv.name = "ram_after_reset";
    run_vec(rv);

    chk("no_overlap", 32'(overlap), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
